// File: rtl/window_5x5_gen_pkg.sv
// window_5x5_gen_pkg: shared window size, coordinate width and FSM encoding
package window_5x5_gen_pkg;
  localparam int WIN = 5;
  localparam int CW = 10;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
endpackage

// File: rtl/window_5x5_gen_if.sv
// window_5x5_gen_if: pixel stream in, 5x5 window and coordinates out
interface window_5x5_gen_if #(parameter int pixelBitWidth = 12);
  import window_5x5_gen_pkg::*;
  logic start;
  logic [pixelBitWidth-1:0] pix_in;
  logic pix_valid;
  logic [WIN*WIN*pixelBitWidth-1:0] win;
  logic win_valid;
  logic [CW-1:0] ctr_row;
  logic [CW-1:0] ctr_col;
  logic frame_done;
  modport master (
    output start, pix_in, pix_valid,
    input win, win_valid, ctr_row, ctr_col, frame_done
  );
  modport slave (
    input start, pix_in, pix_valid,
    output win, win_valid, ctr_row, ctr_col, frame_done
  );
endinterface

// File: rtl/window_5x5_gen_line_buffer.sv
// line_buffer: one image line, combinational read-before-write at a single address
module line_buffer #(
  parameter int W = 12,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o
);
  logic [W-1:0] mem_q [DEPTH];
  assign dout_o = mem_q[addr_i];
  // store the incoming pixel after its old value has been passed on
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= din_i;
endmodule

// File: rtl/window_5x5_gen.sv
// window_5x5_gen: raster pixel stream to sliding 5x5 window with centre coordinates
module window_5x5_gen
  import window_5x5_gen_pkg::*;
#(
  parameter int pixelBitWidth = 12,
  parameter int imgWidth = 64,
  parameter int imgHeight = 48
) (
  input logic clk,
  input logic rst,
  window_5x5_gen_if.slave bus
);
  localparam int PW = pixelBitWidth;
  localparam int AW = $clog2(imgWidth);
  localparam logic [CW-1:0] LAST_COL = CW'(imgWidth - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(imgHeight - 1);
  logic [0:0] state_q, state_d;
  logic [CW-1:0] row_q, row_d, col_q, col_d, cur_row, cur_col;
  logic [CW-1:0] ctr_row_q, ctr_row_d, ctr_col_q, ctr_col_d;
  logic [WIN*WIN*PW-1:0] win_q, win_d;
  logic win_valid_q, frame_done_q, acc, eol, last, hit;
  logic [PW-1:0] line [WIN];
  assign acc = bus.pix_valid && (state_q == ACTIVE || bus.start);
  assign cur_row = bus.start ? '0 : row_q;
  assign cur_col = bus.start ? '0 : col_q;
  assign eol = cur_col == LAST_COL;
  assign last = eol && cur_row == LAST_ROW;
  assign hit = acc && cur_row >= CW'(4) && cur_col >= CW'(4);
  assign line[0] = bus.pix_in;
  genvar g;
  for (g = 0; g < WIN - 1; g++) begin : g_lb
    line_buffer #(.W(PW), .DEPTH(imgWidth)) u_lb (
      .clk   (clk),
      .we_i  (acc),
      .addr_i(cur_col[AW-1:0]),
      .din_i (line[g]),
      .dout_o(line[g+1])
    );
  end
  // raster position, frame state and centre coordinates of the next window
  always_comb begin
    state_d = (acc && last) ? IDLE : (bus.start ? ACTIVE : state_q);
    col_d = acc ? (eol ? '0 : cur_col + CW'(1)) : cur_col;
    row_d = acc ? (last ? '0 : (eol ? cur_row + CW'(1) : cur_row)) : cur_row;
    ctr_row_d = hit ? cur_row - CW'(2) : ctr_row_q;
    ctr_col_d = hit ? cur_col - CW'(2) : ctr_col_q;
  end
  // shift the window left; the oldest line lands in row 0, the live pixel in row 4
  always_comb begin
    win_d = win_q;
    if (acc) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN - 1; c++)
          win_d[(r*WIN+c)*PW +: PW] = win_q[(r*WIN+c+1)*PW +: PW];
        win_d[(r*WIN+WIN-1)*PW +: PW] = line[WIN-1-r];
      end
    end
  end
  // state registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      ctr_row_q <= '0;
      ctr_col_q <= '0;
      win_q <= '0;
      win_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      ctr_row_q <= ctr_row_d;
      ctr_col_q <= ctr_col_d;
      win_q <= win_d;
      win_valid_q <= hit;
      frame_done_q <= acc && last;
    end
  assign bus.win = win_q;
  assign bus.win_valid = win_valid_q;
  assign bus.ctr_row = ctr_row_q;
  assign bus.ctr_col = ctr_col_q;
  assign bus.frame_done = frame_done_q;
endmodule
